operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch sequencer directly upstream of the register file.
//  - Accepts one decoded instruction (rs1/rs2) at a time.
//  - Drives the single-port regfile (one read OR one write per cycle; 2-cycle registered read).
//  - Arbitrates writeback writes onto the same port.
//  - Returns both operands on a valid/ready output, with writeback forwarding.
// PARAMETERS
//  WIDTH  32              data width; regfile depth fixed at 32 entries
//  AW     $clog2(WIDTH)   register select width (5 at default)
// PORTS
//  clk          in   1      single clock, all state on posedge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      decoded instruction valid
//  in_ready     out  1      instruction accepted when in_valid&in_ready
//  in_rs1       in   AW     source register 1
//  in_rs2       in   AW     source register 2
//  in_use_rs1   in   1      rs1 operand required
//  in_use_rs2   in   1      rs2 operand required
//  wb_valid     in   1      writeback request
//  wb_ready     out  1      writeback accepted when wb_valid&wb_ready
//  wb_rd        in   AW     writeback destination
//  wb_val       in   WIDTH  writeback data
//  rf_r_enable  out  1      regfile read enable
//  rf_w_enable  out  1      regfile write enable
//  rf_r_select  out  AW     regfile read address
//  rf_w_select  out  AW     regfile write address
//  rf_w_val     out  WIDTH  regfile write data
//  rf_r_out     in   WIDTH  regfile read data; valid 2 cycles after the read issue cycle
//  out_valid    out  1      operands valid; held until out_ready
//  out_ready    in   1      consumer accepts operands
//  out_op1      out  WIDTH  operand 1; 0 if unused or x0
//  out_op2      out  WIDTH  operand 2; 0 if unused or x0
// BEHAVIOUR
//  - Reset: state IDLE, out_valid=0, out_op1/2=0, tracker and override flags cleared.
//  - Reset: rf_r_enable=rf_w_enable=0 while rst=1; in-flight regfile reads are discarded.
//  - Read need per operand: need_n = in_use_rsn && in_rsn!=0. A not-needed operand yields 0; no read is issued.
//  - Port exclusivity: rf_r_enable and rf_w_enable are never both 1 in the same cycle.
//  - FSM states:
//    - IDLE:
//      - wb_valid=1: write wins; wb_ready=1, in_ready=0.
//      - Otherwise: in_ready=1.
//      - On acceptance (cycle T): latch rs1/rs2/need flags, clear overrides, go to ISSUE.
//      - On acceptance with no reads needed: go straight to DONE.
//    - ISSUE: wb_ready=0. Issue rs1 read (if needed), then rs2 read (if needed) on the next cycle, back-to-back. Then go to WAIT.
//    - WAIT: wb_ready=1. Stay until every issued read has been captured, then go to DONE.
//    - DONE:
//      - out_valid=1; wb_ready=1.
//      - On out_valid&out_ready: go to IDLE.
//      - No same-cycle re-accept; in_ready=0 in DONE.
//  - Capture: a read issued in cycle c is captured from rf_r_out at the end of cycle c+2, routed by a 2-deep tag pipe (none/op1/op2).
//  - Latency from acceptance cycle T:
//    - two reads: issue T+1 and T+2, out_valid first high at T+5
//    - one read: issue T+1, out_valid at T+4
//    - no reads: out_valid at T+1
//  - Writes:
//    - An accepted write drives rf_w_enable=1 with rf_w_select=wb_rd and rf_w_val=wb_val in the same cycle.
//    - wb_rd==0 is accepted but rf_w_enable stays 0.
//  - Forwarding:
//    - Trigger: a write accepted in WAIT or DONE with wb_rd==rsn and need_n=1.
//    - Action: set override_n and store wb_val. out_opn = override_n ? ov_val_n : captured_n.
//    - Applies even when the matching read is still in flight; the later capture does not clear the override.
//    - Youngest write wins on repeated matches.
//    - A write in DONE in the same cycle as the pop still writes the regfile; the override is discarded.
//  - rs1==rs2: both reads are still issued; forwarding updates both operands.
//  - rst mid-sequence: abandon the instruction, no out_valid, no partial capture afterwards.
// STRUCTURE
//  - rv_pkg: AW/WIDTH constants, fetch-state enum {IDLE,ISSUE,WAIT,DONE}, capture-tag enum {TAG_NONE,TAG_OP1,TAG_OP2}.
//  - Sub-module rf_read_tracker: 2-stage tag shift register with sync clear; emits capture strobes for op1/op2.
//  - The FSM, arbitration and override logic stay in operand_fetch.
// TESTING
//  - Bench uses a behavioural regfile model with 2-cycle read latency and read priority.
//  - Preload x5=0x11, x6=0x22; accept rs1=5, rs2=6 at T -> reads issued at T+1/T+2; out_valid at T+5 with op1=0x11, op2=0x22.
//  - rs1=0, use_rs2=0 -> no rf_r_enable pulse; out_valid at T+1 with op1=op2=0.
//  - wb_valid and in_valid together in IDLE -> write done, in_ready=0; instruction accepted next cycle.
//  - rs1=rs2=7 (x7=0x1), write x7=0xAB accepted in WAIT before the captures -> op1=op2=0xAB; regfile x7=0xAB.
//  - out_ready held 0 for 10 cycles -> out_valid/op stable.
//  - Then write x0=0xFF -> no rf_w_enable; x0 still reads 0.
//  - rst asserted at T+3 of a two-read fetch -> out_valid never rises; next fetch after reset returns correct values.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and state/tag enums for the operand fetch path
package rv_pkg;

  localparam int WIDTH = 32;
  localparam int AW    = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } fetch_state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_OP1,
    TAG_OP2
  } cap_tag_e;

endpackage

// File: rtl/rf_read_tracker.sv
// rtl/rf_read_tracker.sv - 2-stage tag pipe that routes regfile read data to op1/op2
module rf_read_tracker
  import rv_pkg::*;
(
  input  logic     clk,
  input  logic     clear,
  input  cap_tag_e issue_tag,
  output logic     cap_op1,
  output logic     cap_op2,
  output logic     in_flight
);

  cap_tag_e tag_d1;
  cap_tag_e tag_d2;

  always_ff @(posedge clk) begin
    if (clear) begin
      tag_d1 <= TAG_NONE;
      tag_d2 <= TAG_NONE;
    end else begin
      tag_d1 <= issue_tag;
      tag_d2 <= tag_d1;
    end
  end

  // tag_d2 lines up with the cycle rf_r_out carries the data
  assign cap_op1   = (tag_d2 == TAG_OP1);
  assign cap_op2   = (tag_d2 == TAG_OP2);
  assign in_flight = (tag_d1 != TAG_NONE);

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch sequencer sharing one regfile port with writeback
module operand_fetch
  import rv_pkg::*;
#(
  parameter int WIDTH = rv_pkg::WIDTH,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [AW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_val,
  output logic             rf_r_enable,
  output logic             rf_w_enable,
  output logic [AW-1:0]    rf_r_select,
  output logic [AW-1:0]    rf_w_select,
  output logic [WIDTH-1:0] rf_w_val,
  input  logic [WIDTH-1:0] rf_r_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_op1,
  output logic [WIDTH-1:0] out_op2
);

  fetch_state_e     state, state_nxt;
  logic [AW-1:0]    rs1_q, rs2_q;
  logic             need1_q, need2_q, op1_issued_q;
  logic [WIDTH-1:0] cap1_q, cap2_q, ov1_q, ov2_q;
  logic             ovr1_q, ovr2_q;

  cap_tag_e         issue_tag;
  logic             rd_issue;
  logic             cap_op1, cap_op2, in_flight;
  logic             need1, need2, accept, wb_fire, pop, fwd_ok;

  assign need1   = in_use_rs1 && (in_rs1 != '0);
  assign need2   = in_use_rs2 && (in_rs2 != '0);
  assign accept  = in_valid && in_ready;
  assign wb_fire = wb_valid && wb_ready;
  assign pop     = out_valid && out_ready;
  // a write racing the pop must not leak an override into the next instruction
  assign fwd_ok  = wb_fire && ((state == WAIT) || ((state == DONE) && !pop));

  rf_read_tracker u_tracker (
    .clk       (clk),
    .clear     (rst),
    .issue_tag (issue_tag),
    .cap_op1   (cap_op1),
    .cap_op2   (cap_op2),
    .in_flight (in_flight)
  );

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    wb_ready    = 1'b0;
    rd_issue    = 1'b0;
    rf_r_select = rs1_q;
    issue_tag   = TAG_NONE;
    case (state)
      IDLE: begin
        wb_ready = 1'b1;
        in_ready = !wb_valid;
        if (accept) state_nxt = (need1 || need2) ? ISSUE : DONE;
      end
      ISSUE: begin
        rd_issue = 1'b1;
        if (need1_q && !op1_issued_q) begin
          rf_r_select = rs1_q;
          issue_tag   = TAG_OP1;
          state_nxt   = need2_q ? ISSUE : WAIT;
        end else begin
          rf_r_select = rs2_q;
          issue_tag   = TAG_OP2;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        wb_ready = 1'b1;
        if (!in_flight) state_nxt = DONE;
      end
      DONE: begin
        wb_ready = 1'b1;
        if (pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rf_r_enable = rd_issue && !rst;
  assign rf_w_enable = wb_fire && (wb_rd != '0) && !rst;
  assign rf_w_select = wb_rd;
  assign rf_w_val    = wb_val;

  assign out_valid = (state == DONE) && !rst;
  assign out_op1   = ovr1_q ? ov1_q : cap1_q;
  assign out_op2   = ovr2_q ? ov2_q : cap2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      need1_q      <= 1'b0;
      need2_q      <= 1'b0;
      op1_issued_q <= 1'b0;
      cap1_q       <= '0;
      cap2_q       <= '0;
      ov1_q        <= '0;
      ov2_q        <= '0;
      ovr1_q       <= 1'b0;
      ovr2_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rs1_q        <= in_rs1;
        rs2_q        <= in_rs2;
        need1_q      <= need1;
        need2_q      <= need2;
        op1_issued_q <= 1'b0;
        cap1_q       <= '0;
        cap2_q       <= '0;
        ov1_q        <= '0;
        ov2_q        <= '0;
        ovr1_q       <= 1'b0;
        ovr2_q       <= 1'b0;
      end
      if (issue_tag == TAG_OP1) op1_issued_q <= 1'b1;
      if (cap_op1) cap1_q <= rf_r_out;
      if (cap_op2) cap2_q <= rf_r_out;
      // override sticks even if the stale read lands afterwards
      if (fwd_ok && need1_q && (wb_rd == rs1_q)) begin
        ovr1_q <= 1'b1;
        ov1_q  <= wb_val;
      end
      if (fwd_ok && need2_q && (wb_rd == rs2_q)) begin
        ovr2_q <= 1'b1;
        ov2_q  <= wb_val;
      end
    end
  end

endmodule
